draw_rect_ctl: RTL and testbench
================================

Name: draw_rect_ctl

Overview:
Motion controller that produces the xpos/ypos sprite position consumed by the rectangle/sprite drawing stage. In IDLE the sprite follows the mouse. A left click drops it under gravity; it bounces off the screen floor with damping and comes to rest. Position updates once per frame, on the rising edge of vsync, so the sprite never tears mid-frame.

Parameters:
SCREEN_H, 600, visible screen height in lines
SCREEN_W, 800, visible screen width in pixels (used only with the optional feature)
RECT_HEIGHT, 64, sprite height; FLOOR = SCREEN_H - RECT_HEIGHT (536 by default)
RECT_WIDTH, 64, sprite width (used only with the optional feature)
GRAVITY, 1, velocity increment per frame, in lines
VMAX, 32, velocity saturation limit
DAMP_SHIFT, 1, bounce damping: vel_after = vel - (vel >> DAMP_SHIFT)
MIN_BOUNCE_V, 2, damped velocity below this value ends the motion
HSTEP, 2, horizontal drift per frame (used only with the optional feature)

Ports:
pclk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
mouse_xpos  in  12  mouse X position
mouse_ypos  in  12  mouse Y position
mouse_left  in  1  left mouse button level, already synchronous to pclk
vsync_in  in  1  vertical sync from the timing chain; its rising edge is the frame tick
xpos  out  12  sprite X position
ypos  out  12  sprite Y position
busy  out  1  high in FALL or RISE

Behaviour:
- Reset: xpos=0, ypos=0, busy=0, vel=0, state=IDLE. Internal edge registers clear to 0.
- Edge detection:
  - click = mouse_left & ~mouse_left_d.
  - tick = vsync_in & ~vsync_d.
  - Both are single-cycle pulses, each with 1 cycle of registration.
- IDLE:
  - Each cycle, xpos <= mouse_xpos and ypos <= min(mouse_ypos, FLOOR).
  - On click: go to FALL and set vel <= 0. xpos and ypos freeze at their current values.
  - tick is ignored in IDLE.
- FALL, on tick:
  - v' = min(vel + GRAVITY, VMAX) and y' = ypos + v'.
  - If y' < FLOOR: ypos <= y', vel <= v'.
  - Otherwise: ypos <= FLOOR, vd = v' - (v' >> DAMP_SHIFT). If vd >= MIN_BOUNCE_V: vel <= vd, go to RISE. Else: vel <= 0, go to STOP.
- RISE, on tick:
  - If vel <= GRAVITY: vel <= 0, go to FALL. ypos is unchanged.
  - Else: ypos <= (vel > ypos) ? 0 : ypos - vel, and vel <= vel - GRAVITY.
- STOP: xpos and ypos hold. On click, go to IDLE.
- Events that arrive outside their state are ignored: click in FALL or RISE, tick in STOP.
- Arithmetic: all arithmetic is unsigned, 12 bits wide. The sums are computed in 13 bits before comparison, so nothing wraps.
- busy is registered together with the state and is high exactly while state is FALL or RISE.
- Latency: the position changes in the cycle after the registered tick, i.e. 2 pclk after the vsync rising edge. This is well inside vertical blanking.
- Reset asserted mid-motion returns the block to IDLE with zeroed outputs on the next edge.

Optional Feature:
Macro: DRAW_RECT_CTL_HDRIFT_EN.
- Defined:
  - On the click that starts FALL, dir <= 1 (moving right).
  - On every tick in FALL or RISE, xpos moves by HSTEP in the direction dir.
  - If the new xpos would reach or exceed SCREEN_W - RECT_WIDTH, clamp xpos to that value and set dir <= 0.
  - If the new xpos would drop below 0, clamp xpos to 0 and set dir <= 1.
- Undefined: xpos is constant outside IDLE and the dir register is absent.

Decomposition:
- Shared package draw_rect_pkg holds:
  - state encoding: IDLE=2'd0, FALL=2'd1, RISE=2'd2, STOP=2'd3;
  - screen constants (SCREEN_W, SCREEN_H);
  - sprite size (RECT_WIDTH, RECT_HEIGHT).
- One sub-module, pulse_edge_det (a registered rising-edge detector), instantiated twice: once for click and once for tick.

Test Plan:
- Reset, then mouse at (100, 200) in IDLE -> within 2 cycles xpos=100, ypos=200, busy=0. Mouse at y=700 -> ypos=536.
- With ypos=530, click, then 3 ticks -> ypos 531, 533, 536, state RISE, vel=2. Next tick -> ypos=534, vel=1. Next tick -> state FALL, vel=0.
- With ypos=535, click, then 1 tick -> ypos=536, state STOP, busy=0. Click -> IDLE; ypos follows the mouse again.
- Click and tick in the same cycle while in FALL -> only the tick is applied, and the state does not change due to the click. With ypos=0, click, then a long fall -> vel saturates at 32 and never exceeds it.
- Assert rst for 1 cycle while in RISE -> next cycle xpos=0, ypos=0, busy=0, state=IDLE.
- With DRAW_RECT_CTL_HDRIFT_EN and xpos=732 at click -> after 1 tick xpos=734, after 2 ticks xpos=736 and dir=0, after 3 ticks xpos=734. Without the macro, xpos stays at 732.

Source files
------------

// File: rtl/draw_rect_pkg.sv
// Shared constants and state encoding for the sprite motion controller.
package draw_rect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FALL = 2'd1,
        RISE = 2'd2,
        STOP = 2'd3
    } state_t;

    localparam int unsigned SCREEN_W    = 800;
    localparam int unsigned SCREEN_H    = 600;
    localparam int unsigned RECT_WIDTH  = 64;
    localparam int unsigned RECT_HEIGHT = 64;

endpackage

// File: rtl/pulse_edge_det.sv
// Registered rising-edge detector: pulse is high for one cycle, one cycle after sig rises.
module pulse_edge_det (
    input  logic pclk,
    input  logic rst,
    input  logic sig,
    output logic pulse
);

    logic sig_d;

    always_ff @(posedge pclk) begin
        if (rst) begin
            sig_d <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sig_d <= sig;
            pulse <= sig & ~sig_d;
        end
    end

endmodule

// File: rtl/draw_rect_ctl.sv
// Sprite motion controller: follows the mouse, drops on click, bounces once per frame tick.
// Optional horizontal drift while moving: define DRAW_RECT_CTL_HDRIFT_EN.
module draw_rect_ctl
    import draw_rect_pkg::*;
#(
    parameter int unsigned SCREEN_H     = draw_rect_pkg::SCREEN_H,
    parameter int unsigned RECT_HEIGHT  = draw_rect_pkg::RECT_HEIGHT,
    parameter int unsigned GRAVITY      = 1,
    parameter int unsigned VMAX         = 32,
    parameter int unsigned DAMP_SHIFT   = 1,
    parameter int unsigned MIN_BOUNCE_V = 2
`ifdef DRAW_RECT_CTL_HDRIFT_EN
    ,
    parameter int unsigned SCREEN_W     = draw_rect_pkg::SCREEN_W,
    parameter int unsigned RECT_WIDTH   = draw_rect_pkg::RECT_WIDTH,
    parameter int unsigned HSTEP        = 2
`endif
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    input  logic        vsync_in,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        busy
);

    localparam logic [12:0] FLOOR = 13'(SCREEN_H - RECT_HEIGHT);

    state_t      state;
    logic [11:0] vel;
    logic        click;
    logic        tick;

    pulse_edge_det u_click_det (
        .pclk  (pclk),
        .rst   (rst),
        .sig   (mouse_left),
        .pulse (click)
    );

    pulse_edge_det u_tick_det (
        .pclk  (pclk),
        .rst   (rst),
        .sig   (vsync_in),
        .pulse (tick)
    );

    logic [12:0] vel_inc;
    logic [11:0] vel_sat;
    logic [11:0] vel_damp;
    logic [12:0] y_sum;
    logic [11:0] y_rise;
    logic [11:0] y_clip;

    // Sums are widened to 13 bits so comparisons never see a wrapped value.
    always_comb begin
        vel_inc  = {1'b0, vel} + 13'(GRAVITY);
        vel_sat  = (vel_inc > 13'(VMAX)) ? 12'(VMAX) : vel_inc[11:0];
        vel_damp = vel_sat - (vel_sat >> DAMP_SHIFT);
        y_sum    = {1'b0, ypos} + {1'b0, vel_sat};
        y_rise   = (vel > ypos) ? 12'd0 : ypos - vel;
        y_clip   = ({1'b0, mouse_ypos} > FLOOR) ? FLOOR[11:0] : mouse_ypos;
    end

`ifdef DRAW_RECT_CTL_HDRIFT_EN
    localparam logic [12:0] XMAX = 13'(SCREEN_W - RECT_WIDTH);

    logic        dir;
    logic [11:0] x_drift;
    logic        dir_drift;
    logic [12:0] x_right;

    always_comb begin
        x_right   = {1'b0, xpos} + 13'(HSTEP);
        x_drift   = xpos;
        dir_drift = dir;
        if (dir) begin
            if (x_right >= XMAX) begin
                x_drift   = XMAX[11:0];
                dir_drift = 1'b0;
            end else begin
                x_drift = x_right[11:0];
            end
        end else if ({1'b0, xpos} < 13'(HSTEP)) begin
            x_drift   = 12'd0;
            dir_drift = 1'b1;
        end else begin
            x_drift = xpos - 12'(HSTEP);
        end
    end
`endif

    always_ff @(posedge pclk) begin
        if (rst) begin
            state <= IDLE;
            xpos  <= 12'd0;
            ypos  <= 12'd0;
            vel   <= 12'd0;
            busy  <= 1'b0;
`ifdef DRAW_RECT_CTL_HDRIFT_EN
            dir   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (click) begin
                        state <= FALL;
                        busy  <= 1'b1;
                        vel   <= 12'd0;
`ifdef DRAW_RECT_CTL_HDRIFT_EN
                        dir   <= 1'b1;
`endif
                    end else begin
                        xpos <= mouse_xpos;
                        ypos <= y_clip;
                    end
                end
                FALL: begin
                    if (tick) begin
`ifdef DRAW_RECT_CTL_HDRIFT_EN
                        xpos <= x_drift;
                        dir  <= dir_drift;
`endif
                        if (y_sum < FLOOR) begin
                            ypos <= y_sum[11:0];
                            vel  <= vel_sat;
                        end else begin
                            ypos <= FLOOR[11:0];
                            if (vel_damp >= 12'(MIN_BOUNCE_V)) begin
                                vel   <= vel_damp;
                                state <= RISE;
                            end else begin
                                vel   <= 12'd0;
                                state <= STOP;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                RISE: begin
                    if (tick) begin
`ifdef DRAW_RECT_CTL_HDRIFT_EN
                        xpos <= x_drift;
                        dir  <= dir_drift;
`endif
                        if (vel <= 12'(GRAVITY)) begin
                            vel   <= 12'd0;
                            state <= FALL;
                        end else begin
                            ypos <= y_rise;
                            vel  <= vel - 12'(GRAVITY);
                        end
                    end
                end
                STOP: begin
                    if (click) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Self-checking bench for draw_rect_ctl: directed test-plan scenarios plus random stimulus.
module tb_draw_rect_ctl;

    logic        pclk = 1'b0;
    logic        rst;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic        vsync_in;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        busy;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    localparam int FLOOR_M = 536;
    localparam int XMAX_M  = 736;

    draw_rect_ctl dut (
        .pclk       (pclk),
        .rst        (rst),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .mouse_left (mouse_left),
        .vsync_in   (vsync_in),
        .xpos       (xpos),
        .ypos       (ypos),
        .busy       (busy)
    );

    always #5 pclk = ~pclk;

    // Reference model: mode 0 follow, 1 falling, 2 rising, 3 resting.
    int m_mode, m_x, m_y, m_vel, m_dir;
    bit m_click, m_tick, m_lprev, m_vprev;

    task automatic drift();
`ifdef DRAW_RECT_CTL_HDRIFT_EN
        int nx;
        nx = m_x + (m_dir ? 2 : -2);
        if (nx >= XMAX_M) begin
            nx = XMAX_M;
            m_dir = 0;
        end else if (nx < 0) begin
            nx = 0;
            m_dir = 1;
        end
        m_x = nx;
`endif
    endtask

    always @(posedge pclk) begin
        if (rst) begin
            m_mode = 0; m_x = 0; m_y = 0; m_vel = 0; m_dir = 0;
            m_click = 0; m_tick = 0; m_lprev = 0; m_vprev = 0;
        end else begin
            int v, vd;
            case (m_mode)
                0: if (m_click) begin
                    m_mode = 1; m_vel = 0; m_dir = 1;
                end else begin
                    m_x = int'(mouse_xpos);
                    m_y = (int'(mouse_ypos) > FLOOR_M) ? FLOOR_M : int'(mouse_ypos);
                end
                1: if (m_tick) begin
                    drift();
                    v = (m_vel + 1 > 32) ? 32 : m_vel + 1;
                    if (m_y + v < FLOOR_M) begin
                        m_y = m_y + v;
                        m_vel = v;
                    end else begin
                        m_y = FLOOR_M;
                        vd = v - v / 2;
                        if (vd >= 2) begin
                            m_vel = vd; m_mode = 2;
                        end else begin
                            m_vel = 0; m_mode = 3;
                        end
                    end
                end
                2: if (m_tick) begin
                    drift();
                    if (m_vel <= 1) begin
                        m_vel = 0; m_mode = 1;
                    end else begin
                        m_y = (m_vel > m_y) ? 0 : m_y - m_vel;
                        m_vel = m_vel - 1;
                    end
                end
                default: if (m_click) m_mode = 0;
            endcase
            m_click = mouse_left && !m_lprev;
            m_tick  = vsync_in && !m_vprev;
            m_lprev = mouse_left;
            m_vprev = vsync_in;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge pclk) begin
        if (checking) begin
            check("m_xpos", int'(xpos), m_x);
            check("m_ypos", int'(ypos), m_y);
            check("m_busy", int'(busy), (m_mode == 1 || m_mode == 2) ? 1 : 0);
            check("m_vel", int'(dut.vel), m_vel);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic do_tick();
        vsync_in = 1'b1; step(2);
        vsync_in = 1'b0; step(2);
    endtask

    task automatic do_click();
        mouse_left = 1'b1; step(2);
        mouse_left = 1'b0; step(2);
    endtask

    task automatic set_mouse(input int x, input int y);
        mouse_xpos = 12'(x);
        mouse_ypos = 12'(y);
        step(2);
    endtask

    initial begin
        rst = 1'b1; mouse_xpos = '0; mouse_ypos = '0; mouse_left = 1'b0; vsync_in = 1'b0;
        step(1);
        checking = 1'b1;
        step(1);
        check("rst_x", int'(xpos), 0);
        check("rst_y", int'(ypos), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;

        set_mouse(100, 200);
        check("follow_x", int'(xpos), 100);
        check("follow_y", int'(ypos), 200);
        check("follow_busy", int'(busy), 0);
        set_mouse(100, 700);
        check("floor_clip_y", int'(ypos), 536);

        // Drop from 530: three falling ticks, bounce, then fall again.
        set_mouse(732, 530);
        do_click();
        check("drop_busy", int'(busy), 1);
        do_tick(); check("t1_y", int'(ypos), 531);
`ifdef DRAW_RECT_CTL_HDRIFT_EN
        check("t1_x", int'(xpos), 734);
`else
        check("t1_x", int'(xpos), 732);
`endif
        do_tick(); check("t2_y", int'(ypos), 533);
`ifdef DRAW_RECT_CTL_HDRIFT_EN
        check("t2_x", int'(xpos), 736);
`else
        check("t2_x", int'(xpos), 732);
`endif
        do_tick(); check("t3_y", int'(ypos), 536);
        check("t3_vel", int'(dut.vel), 2);
        check("t3_state", int'(dut.state), 2);
`ifdef DRAW_RECT_CTL_HDRIFT_EN
        check("t3_x", int'(xpos), 734);
`else
        check("t3_x", int'(xpos), 732);
`endif
        do_tick(); check("t4_y", int'(ypos), 534);
        check("t4_vel", int'(dut.vel), 1);
        do_tick(); check("t5_state", int'(dut.state), 1);
        check("t5_vel", int'(dut.vel), 0);
        do_tick(); do_tick();
        check("settle_busy", int'(busy), 0);
        check("settle_y", int'(ypos), 536);
        do_click();

        // Drop from 535: lands and stops in one tick.
        set_mouse(200, 535);
        do_click();
        do_tick();
        check("stop_y", int'(ypos), 536);
        check("stop_state", int'(dut.state), 3);
        check("stop_busy", int'(busy), 0);
        do_tick();
        check("stop_hold_y", int'(ypos), 536);
        do_click();
        set_mouse(200, 300);
        check("refollow_y", int'(ypos), 300);

        // Click coincident with tick while falling.
        set_mouse(300, 100);
        do_click();
        mouse_left = 1'b1; vsync_in = 1'b1; step(2);
        mouse_left = 1'b0; vsync_in = 1'b0; step(2);
        check("coinc_busy", int'(busy), 1);
        check("coinc_y", int'(ypos), 101);

        // Long fall from the top: velocity saturates at 32.
        rst = 1'b1; step(1); rst = 1'b0;
        set_mouse(0, 0);
        do_click();
        repeat (32) do_tick();
        check("sat_vel", int'(dut.vel), 32);
        check("sat_y", int'(ypos), 528);
        do_tick();
        check("bounce_vel", int'(dut.vel), 16);
        check("bounce_y", int'(ypos), 536);
        do_tick();
        check("rise_y", int'(ypos), 520);
        mouse_xpos = 12'd50; mouse_ypos = 12'd60;
        rst = 1'b1; step(1); rst = 1'b0;
        check("midrst_x", int'(xpos), 0);
        check("midrst_y", int'(ypos), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_state", int'(dut.state), 0);
        step(2);

        // Random phase checked cycle by cycle against the model.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 3) == 0) vsync_in = ~vsync_in;
            if ($urandom_range(0, 59) == 0) mouse_left = ~mouse_left;
            if ($urandom_range(0, 7) == 0) begin
                mouse_xpos = 12'($urandom_range(0, 1000));
                mouse_ypos = 12'($urandom_range(0, 800));
            end
            if ($urandom_range(0, 1999) == 0) rst = 1'b1;
            else rst = 1'b0;
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
